// File: rtl/uart_tx_sched_pkg.sv
// Shared UART definitions: parity codes, frame bit positions, scheduler states
// and the combinational frame builder used by the TX scheduler.
package uart_tx_sched_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int FRAME_W      = 12;
    localparam int FRM_START    = 0;
    localparam int FRM_DATA_LSB = 1;
    localparam int FRM_PARITY   = 9;
    localparam int FRM_STOP1    = 10;
    localparam int FRM_STOP2    = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_BUSY = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic       data_length;
        logic [1:0] parity_type;
        logic       stop_bits;
    } uart_cfg_t;

    // Unused positions default to 1: bit 8 in 7-bit mode, parity when disabled,
    // and both stop bits regardless of the stop-bit setting.
    function automatic logic [FRAME_W-1:0] uart_frame_build(input logic [7:0] d,
                                                            input uart_cfg_t cfg);
        logic [FRAME_W-1:0] f;
        logic               px;
        f            = '1;
        f[FRM_START] = 1'b0;
        if (cfg.data_length) begin
            f[FRM_DATA_LSB +: 8] = d;
            px = ^d;
        end else begin
            f[FRM_DATA_LSB +: 7] = d[6:0];
            px = ^d[6:0];
        end
        case (cfg.parity_type)
            PAR_EVEN: f[FRM_PARITY] = px;
            PAR_ODD:  f[FRM_PARITY] = ~px;
            default:  f[FRM_PARITY] = 1'b1;
        endcase
        f[FRM_STOP1] = 1'b1;
        f[FRM_STOP2] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester-side byte handshake bus: per-requester valid/data in, one-hot ready out.
interface uart_tx_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][7:0]  req_data;
    logic [NREQ-1:0]       req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past last_grant and wraps; returns a
// one-hot grant plus its index. Reusable for any shared UART resource.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);
    always_comb begin
        int          idx;
        logic [IW-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = IW'(idx);
            if (!grant_vld && req[sel]) begin
                grant_vld  = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART serializer: grants a requester, latches
// its frame and config, then sequences send / tx_active / tx_done one frame at a time.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int TIMEOUT = 8,
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic               baud_clk,
    input  logic               arst_n,
    uart_tx_sched_if.slave     req_bus,
    input  logic               cfg_data_length,
    input  logic [1:0]         cfg_parity_type,
    input  logic               cfg_stop_bits,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic               send,
    output logic [FRAME_W-1:0] frame_out,
    output logic               data_length_out,
    output logic [1:0]         parity_type_out,
    output logic               stop_bits_out,
    output logic               busy,
    output logic               done_pulse,
    output logic [IW-1:0]      done_id,
    output logic               err_timeout
);
    sched_state_t    state, state_nx;
    logic [IW-1:0]   last_grant;
    logic [CW-1:0]   cnt;
    uart_cfg_t       cfg_in, cfg_q;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_vld;
    logic            accept, to_hit, fin;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    assign cfg_in            = {cfg_data_length, cfg_parity_type, cfg_stop_bits};
    assign req_bus.req_ready = (state == ST_IDLE) ? grant : '0;
    assign busy              = (state != ST_IDLE);
    assign data_length_out   = cfg_q.data_length;
    assign parity_type_out   = cfg_q.parity_type;
    assign stop_bits_out     = cfg_q.stop_bits;

    always_ff @(posedge baud_clk or negedge arst_n) begin
        if (!arst_n) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // tx_active wins over the timeout when both land in the same cycle.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        to_hit   = 1'b0;
        fin      = 1'b0;
        case (state)
            ST_IDLE: if (grant_vld) begin
                accept   = 1'b1;
                state_nx = ST_SEND;
            end
            ST_SEND: if (tx_active) begin
                state_nx = ST_BUSY;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                to_hit   = 1'b1;
                state_nx = ST_IDLE;
            end
            ST_BUSY: if (tx_done) begin
                fin      = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk or negedge arst_n) begin
        if (!arst_n) begin
            send        <= 1'b0;
            frame_out   <= '1;
            cfg_q       <= '0;
            last_grant  <= IW'(NREQ - 1);
            cnt         <= '0;
            done_pulse  <= 1'b0;
            done_id     <= '0;
            err_timeout <= 1'b0;
        end else begin
            send        <= (state_nx == ST_SEND);
            cnt         <= (state == ST_SEND) ? cnt + 1'b1 : '0;
            done_pulse  <= fin;
            err_timeout <= to_hit;
            if (fin) done_id <= last_grant;
            if (accept) begin
                frame_out  <= uart_frame_build(req_bus.req_data[grant_idx], cfg_in);
                cfg_q      <= cfg_in;
                last_grant <= grant_idx;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a predictor pushes expected frames and
// completions, a monitor pops them when the DUT presents send / done / timeout.
module tb_uart_tx_sched;
    localparam int NREQ = 3, TIMEOUT = 8, IW = 2;

    logic baud_clk = 1'b0, arst_n = 1'b0;
    logic cfg_data_length, cfg_stop_bits, tx_active, tx_done;
    logic [1:0] cfg_parity_type, parity_type_out;
    logic send, data_length_out, stop_bits_out, busy, done_pulse, err_timeout;
    logic [11:0] frame_out;
    logic [IW-1:0] done_id;
    logic ser_en;

    uart_tx_sched_if #(.NREQ(NREQ)) bus ();

    uart_tx_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .baud_clk(baud_clk), .arst_n(arst_n), .req_bus(bus.slave),
        .cfg_data_length(cfg_data_length), .cfg_parity_type(cfg_parity_type),
        .cfg_stop_bits(cfg_stop_bits), .tx_active(tx_active), .tx_done(tx_done),
        .send(send), .frame_out(frame_out), .data_length_out(data_length_out),
        .parity_type_out(parity_type_out), .stop_bits_out(stop_bits_out), .busy(busy),
        .done_pulse(done_pulse), .done_id(done_id), .err_timeout(err_timeout));

    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic [11:0] frame;
        logic        dl;
        logic [1:0]  pt;
        logic        sb;
    } exp_t;

    exp_t acc_q[$];
    int   done_q[$];
    int   to_pend = 0;
    int   n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference frame from plain arithmetic: stop bits 0xC00, parity at 512, data shifted past start.
    function automatic logic [11:0] ref_frame(input logic [7:0] d, input logic dl, input logic [1:0] pt);
        int nbits, ones, data, par;
        nbits = dl ? 8 : 7;
        ones  = 0;
        for (int i = 0; i < nbits; i++) ones += (int'(d) >> i) & 1;
        data = dl ? int'(d) : ((int'(d) & 127) + 128);
        if (pt == 2'b10)      par = ones % 2;
        else if (pt == 2'b01) par = 1 - (ones % 2);
        else                  par = 1;
        return 12'(3072 + par * 512 + data * 2);
    endfunction

    // Serializer stand-in: raises tx_active 0..2 cycles after send, holds it, then a tx_done cycle.
    initial begin
        int ph, dly, blen;
        tx_active = 1'b0; tx_done = 1'b0; ph = 0; dly = 0; blen = 0;
        forever begin
            @(posedge baud_clk); #1;
            if (!arst_n || !ser_en) begin
                tx_active = 1'b0; tx_done = 1'b0; ph = 0;
            end else begin
                case (ph)
                    0: if (send) begin
                        dly = $urandom_range(0, 2);
                        if (dly == 0) begin tx_active = 1'b1; blen = $urandom_range(2, 5); ph = 2; end
                        else begin dly--; ph = 1; end
                    end
                    1: if (dly == 0) begin tx_active = 1'b1; blen = $urandom_range(2, 5); ph = 2; end
                       else dly--;
                    2: if (blen == 0) begin tx_done = 1'b1; ph = 3; end
                       else blen--;
                    default: begin tx_active = 1'b0; tx_done = 1'b0; ph = 0; end
                endcase
            end
        end
    end

    // Predictor: checks current-cycle behaviour, then predicts the next edge.
    initial begin
        int m_phase, m_last, m_cnt, g;
        logic [NREQ-1:0] exp_ready;
        exp_t e;
        m_phase = 0; m_last = NREQ - 1; m_cnt = 0;
        forever begin
            @(negedge baud_clk);
            if (!arst_n) begin
                m_phase = 0; m_last = NREQ - 1; m_cnt = 0;
                acc_q.delete(); done_q.delete(); to_pend = 0;
            end else begin
                check("busy", 32'(busy), 32'(m_phase != 0));
                check("send", 32'(send), 32'(m_phase == 1));
                g = -1;
                exp_ready = '0;
                if (m_phase == 0)
                    for (int k = 1; k <= NREQ; k++)
                        if (g < 0 && ((bus.req_valid >> ((m_last + k) % NREQ)) & 3'b1) != 0)
                            g = (m_last + k) % NREQ;
                if (g >= 0) exp_ready = NREQ'(1 << g);
                check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
                case (m_phase)
                    0: if (g >= 0) begin
                        e.frame = ref_frame(bus.req_data[IW'(g)], cfg_data_length, cfg_parity_type);
                        e.dl = cfg_data_length; e.pt = cfg_parity_type; e.sb = cfg_stop_bits;
                        acc_q.push_back(e);
                        m_last = g; m_phase = 1; m_cnt = 0;
                    end
                    1: if (tx_active) m_phase = 2;
                       else begin
                           m_cnt++;
                           if (m_cnt == TIMEOUT) begin to_pend++; m_phase = 0; end
                       end
                    default: if (tx_done) begin done_q.push_back(m_last); m_phase = 0; end
                endcase
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a frame, a completion or a timeout.
    initial begin
        logic prev_send, cur_vld;
        exp_t cur, e;
        prev_send = 1'b0; cur_vld = 1'b0;
        forever begin
            @(negedge baud_clk);
            if (!arst_n) begin
                prev_send = 1'b0; cur_vld = 1'b0;
            end else begin
                if (send && !prev_send) begin
                    if (acc_q.size() == 0) check("unexpected_send", 32'(1), 32'(0));
                    else begin
                        e = acc_q.pop_front();
                        check("frame_out", 32'(frame_out), 32'(e.frame));
                        check("data_length_out", 32'(data_length_out), 32'(e.dl));
                        check("parity_type_out", 32'(parity_type_out), 32'(e.pt));
                        check("stop_bits_out", 32'(stop_bits_out), 32'(e.sb));
                        cur = e; cur_vld = 1'b1;
                    end
                end else if (cur_vld) begin
                    check("frame_hold", 32'(frame_out), 32'(cur.frame));
                    check("parity_hold", 32'(parity_type_out), 32'(cur.pt));
                end
                if (done_pulse) begin
                    if (done_q.size() == 0) check("unexpected_done", 32'(1), 32'(0));
                    else check("done_id", 32'(done_id), 32'(done_q.pop_front()));
                end
                if (err_timeout) begin
                    check("timeout_expected", 32'(to_pend > 0), 32'(1));
                    if (to_pend > 0) to_pend--;
                end
                prev_send = send;
            end
        end
    end

    task automatic set_cfg(input logic dl, input logic [1:0] pt, input logic sb);
        cfg_data_length = dl; cfg_parity_type = pt; cfg_stop_bits = sb;
    endtask

    // Raise valid on one channel, wait for its ready, drop valid after the accepting edge.
    task automatic send_one(input logic [IW-1:0] ch, input logic [7:0] d);
        bit got;
        got = 1'b0;
        bus.req_data[ch] = d;
        bus.req_valid[ch] = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge baud_clk);
            if (bus.req_ready[ch]) got = 1'b1;
        end
        if (!got) check("accept_wait", 32'(0), 32'(1));
        @(posedge baud_clk); #1;
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < max && !idle; i++) begin
            @(negedge baud_clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check("idle_wait", 32'(0), 32'(1));
        @(posedge baud_clk); #1;
    endtask

    task automatic wait_busy_phase();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge baud_clk);
            if (busy && !send) hit = 1'b1;
        end
        if (!hit) check("busy_wait", 32'(0), 32'(1));
    endtask

    initial begin
        int cyc, gidx;
        bit got;
        bus.req_valid = '0; bus.req_data = '0; ser_en = 1'b1;
        set_cfg(1'b0, 2'b00, 1'b0);
        repeat (3) @(posedge baud_clk);
        #1;
        check("rst_send", 32'(send), 32'(0));
        check("rst_frame", 32'(frame_out), 32'hFFF);
        check("rst_cfg", 32'({data_length_out, parity_type_out, stop_bits_out}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'({done_pulse, done_id, err_timeout}), 32'(0));
        check("rst_ready", 32'(bus.req_ready), 32'(0));
        arst_n = 1'b1;
        @(posedge baud_clk); #1;

        // 8-bit even parity, two stops
        set_cfg(1'b1, 2'b10, 1'b1);
        send_one(2'd0, 8'hCE);
        check("t1_frame", 32'(frame_out), 32'hF9C);
        check("t1_send", 32'(send), 32'(1));
        wait_idle(40);

        // 7-bit odd parity
        set_cfg(1'b0, 2'b01, 1'b0);
        send_one(2'd1, 8'h41);
        check("t2_frame", 32'(frame_out), 32'hF82);
        check("t2_parity_bit", 32'(frame_out[9]), 32'(1));
        wait_idle(40);

        // Two requesters held valid: grants must alternate starting with 0
        set_cfg(1'b1, 2'b10, 1'b0);
        bus.req_data[0] = 8'($urandom); bus.req_data[1] = 8'($urandom);
        bus.req_valid = 3'b011;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0; gidx = -1;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge baud_clk);
                if (bus.req_ready != '0) begin
                    got = 1'b1;
                    gidx = (bus.req_ready == 3'b001) ? 0 : (bus.req_ready == 3'b010) ? 1 : 7;
                end
            end
            check("alt_grant", 32'(gidx), 32'(n % 2));
            @(posedge baud_clk); #1;
            bus.req_data[0] = 8'($urandom); bus.req_data[1] = 8'($urandom);
        end
        bus.req_valid = '0;
        wait_idle(40);

        // Config change while BUSY must not disturb the latched frame/config
        set_cfg(1'b1, 2'b10, 1'b0);
        send_one(2'd0, 8'h5A);
        wait_busy_phase();
        @(posedge baud_clk); #1;
        cfg_parity_type = 2'b01;
        @(negedge baud_clk);
        check("t4_parity_hold", 32'(parity_type_out), 32'(2'b10));
        check("t4_frame_hold", 32'(frame_out), 32'(ref_frame(8'h5A, 1'b1, 2'b10)));
        wait_idle(40);

        // No serializer response: timeout after TIMEOUT cycles in SEND
        ser_en = 1'b0;
        send_one(2'd1, 8'h33);
        got = 1'b0; cyc = 0;
        for (int i = 0; i < 4 * TIMEOUT && !got; i++) begin
            @(negedge baud_clk);
            cyc++;
            if (err_timeout) got = 1'b1;
        end
        check("to_latency", 32'(cyc), 32'(TIMEOUT + 1));
        check("to_send_low", 32'(send), 32'(0));
        check("to_idle", 32'(busy), 32'(0));
        @(posedge baud_clk); #1;
        ser_en = 1'b1;
        repeat (3) @(posedge baud_clk);
        #1;

        // Randomized traffic across all requesters and configurations
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NREQ; c++) begin
                bus.req_valid[c] = ($urandom_range(0, 9) < 4);
                bus.req_data[c]  = 8'($urandom);
            end
            set_cfg(1'($urandom), 2'($urandom), 1'($urandom));
            @(posedge baud_clk); #1;
        end
        bus.req_valid = '0;
        wait_idle(40);

        // Reset during BUSY: frame dropped, arbitration restarts at requester 0
        set_cfg(1'b1, 2'b01, 1'b1);
        send_one(2'd1, 8'h96);
        wait_busy_phase();
        @(posedge baud_clk); #1;
        bus.req_data[0] = 8'hA5; bus.req_data[1] = 8'h3C;
        bus.req_valid = 3'b011;
        arst_n = 1'b0;
        #1;
        check("mrst_send", 32'(send), 32'(0));
        check("mrst_frame", 32'(frame_out), 32'hFFF);
        check("mrst_busy", 32'(busy), 32'(0));
        check("mrst_ready", 32'(bus.req_ready), 32'(3'b001));
        @(posedge baud_clk); #1;
        arst_n = 1'b1;
        @(negedge baud_clk);
        check("post_rst_grant", 32'(bus.req_ready), 32'(3'b001));
        @(posedge baud_clk); #1;
        bus.req_valid = '0;
        wait_idle(40);

        repeat (4) @(posedge baud_clk);
        #1;
        check("acc_q_empty", 32'(acc_q.size()), 32'(0));
        check("done_q_empty", 32'(done_q.size()), 32'(0));
        check("timeout_pending", 32'(to_pend), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
